// File: rtl/io_switch_led.sv
// Memory-mapped board I/O: a registered LED write port and debounced switches with a
// sticky, clear-on-read change-event register, read back combinationally on io_rdata.
module io_switch_led #(
    parameter int          DEBOUNCE_CYCLES = 20000,
    parameter logic [31:0] LED_ADDR        = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR         = 32'hFFFFFC70,
    parameter logic [31:0] EVT_ADDR        = 32'hFFFFFC74
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [15:0] sw_raw,
    output logic [15:0] leds
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [15:0]      r_leds;
    logic [15:0]      r_s1;
    logic [15:0]      r_s2;
    logic [15:0]      r_sw_db;
    logic [15:0]      r_evt;
    logic [CNT_W-1:0] r_cnt [16];

    logic             w_led_sel;
    logic             w_sw_sel;
    logic             w_evt_sel;
    logic             w_led_wr;
    logic             w_evt_rd;
    logic [15:0]      w_accept;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    // Access protocol: io_read/io_write are single-cycle strobes with no handshake; a read
    // returns data in the same cycle, a write lands on the next rising edge.
    assign w_led_sel      = (io_addr == LED_ADDR);
    assign w_sw_sel       = (io_addr == SW_ADDR);
    assign w_evt_sel      = (io_addr == EVT_ADDR);
    assign w_led_wr       = io_write && w_led_sel;
    assign w_evt_rd       = io_read && w_evt_sel;
    assign w_unused_wdata = ^io_wdata[31:16];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_leds <= '0;
        end else if (w_led_wr) begin
            r_leds <= io_wdata[15:0];
        end
    end

    assign leds = r_leds;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_raw;
            r_s2 <= r_s1;
        end
    end

    // A bit is accepted when it has disagreed with its stable value for a full window.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < 16; i++) begin
            w_accept[i] = (r_s2[i] != r_sw_db[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if ((r_s2[i] == r_sw_db[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_db <= '0;
        end else begin
            r_sw_db <= r_sw_db ^ w_accept;
        end
    end

    // New events take priority over the read-clear so an edge landing on the read is kept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_evt <= '0;
        end else begin
            r_evt <= w_accept | (r_evt & ~{16{w_evt_rd}});
        end
    end

    always_comb begin
        w_rdata = '0;
        if (reset && io_read) begin
            if (w_led_sel) begin
                w_rdata = {16'h0, r_leds};
            end else if (w_sw_sel) begin
                w_rdata = {16'h0, r_sw_db};
            end else if (w_evt_sel) begin
                w_rdata = {16'h0, r_evt};
            end
        end
    end

    assign io_rdata = w_rdata;

endmodule

// File: tb/tb_io_switch_led.sv
// Bench for io_switch_led: directed scenarios plus randomized traffic, every cycle checked
// against a window-based behavioural model of the synchronizer, debouncer and event register.
module tb_io_switch_led;

    localparam int          N     = 4;
    localparam logic [31:0] LED_A = 32'hFFFFFC60;
    localparam logic [31:0] SW_A  = 32'hFFFFFC70;
    localparam logic [31:0] EVT_A = 32'hFFFFFC74;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        io_read  = 1'b0;
    logic        io_write = 1'b0;
    logic [31:0] io_addr  = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic [15:0] sw_raw   = '0;
    logic [15:0] leds;

    io_switch_led #(.DEBOUNCE_CYCLES(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_read  (io_read),
        .io_write (io_write),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .sw_raw   (sw_raw),
        .leds     (leds)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sync is a 2-deep delay; a bit flips once the last N delayed samples all disagree with it.
    logic [15:0] m_led, m_db, m_evt, m_p1, m_p2;
    logic [15:0] m_win [$];

    task automatic model_reset();
        m_led = '0; m_db = '0; m_evt = '0; m_p1 = '0; m_p2 = '0;
        m_win.delete();
    endtask

    function automatic logic [31:0] model_rdata();
        if (!reset || !io_read) return 32'h0;
        if (io_addr == LED_A) return {16'h0, m_led};
        if (io_addr == SW_A)  return {16'h0, m_db};
        if (io_addr == EVT_A) return {16'h0, m_evt};
        return 32'h0;
    endfunction

    task automatic model_edge();
        logic [15:0] acc;
        if (!reset) begin
            model_reset();
        end else begin
            m_win.push_back(m_p2);
            if (m_win.size() > N) void'(m_win.pop_front());
            acc = (m_win.size() == N) ? 16'hFFFF : 16'h0;
            foreach (m_win[j]) acc &= (m_win[j] ^ m_db);
            if (io_read && io_addr == EVT_A) m_evt = '0;
            m_evt = m_evt | acc;
            m_db  = m_db ^ acc;
            m_p2  = m_p1;
            m_p1  = sw_raw;
            if (io_write && io_addr == LED_A) m_led = io_wdata[15:0];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        exp_q.push_back(model_rdata());
        @(negedge clock);
        check_eq("rdata", io_rdata, exp_q.pop_front());
        check_eq("leds", {16'h0, leds}, {16'h0, m_led});
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        io_read = 1'b0; io_write = 1'b0; io_addr = '0; io_wdata = '0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
        io_read = 1'b0; io_write = 1'b1; io_addr = a; io_wdata = d;
    endtask

    task automatic drive_read(input logic [31:0] a);
        io_read = 1'b1; io_write = 1'b0; io_addr = a; io_wdata = '0;
    endtask

    // Reads SW after each of 6 edges: 0 through edge 5, exp after edge 6.
    task automatic expect_accept(input string tag, input logic [31:0] exp);
        drive_read(SW_A);
        for (int k = 1; k <= N + 2; k++) begin
            cycle();
            check_eq(tag, io_rdata, (k == N + 2) ? exp : 32'h0);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] addr_tbl [5];

    initial begin
        model_reset();
        // 1. reset and LED write
        drive_read(LED_A);
        cycle();
        cycle();
        check_eq("rst_leds", {16'h0, leds}, 32'h0);
        check_eq("rst_rdata", io_rdata, 32'h0);
        reset = 1'b1;
        drive_write(LED_A, 32'hDEAD_A5A5);
        cycle();
        check_eq("led_wr", {16'h0, leds}, 32'h0000_A5A5);
        drive_read(LED_A);
        #1;
        check_eq("led_rd", io_rdata, 32'h0000_A5A5);
        cycle();
        drive_write(LED_A + 32'd4, 32'h0000_1111);
        cycle();
        drive_write(SW_A, 32'h0000_2222);
        cycle();
        check_eq("led_keep", {16'h0, leds}, 32'h0000_A5A5);

        // 2. debounce accept
        sw_raw = 16'h0003;
        expect_accept("sw_accept", 32'h3);
        drive_read(EVT_A);
        #1;
        check_eq("evt_rd1", io_rdata, 32'h3);
        cycle();
        check_eq("evt_rd2", io_rdata, 32'h0);
        cycle();

        // 3. glitch reject
        drive_read(SW_A);
        sw_raw[5] = 1'b1;
        for (int k = 0; k < N - 1; k++) cycle();
        sw_raw[5] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check_eq("glitch_sw", io_rdata, 32'h3);
        end
        drive_read(EVT_A);
        #1;
        check_eq("glitch_evt", io_rdata, 32'h0);
        cycle();

        // 4. set/clear collision on the event register
        drive_idle();
        sw_raw[2] = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        sw_raw[7] = 1'b1;
        for (int k = 0; k < N + 1; k++) cycle();
        drive_read(EVT_A);
        #1;
        check_eq("coll_rd", io_rdata, 32'h4);
        cycle();
        check_eq("coll_after", io_rdata, 32'h80);
        cycle();

        // 5. asynchronous reset mid-debounce
        drive_write(LED_A, 32'h0000_FFFF);
        cycle();
        drive_idle();
        sw_raw[8] = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        drive_read(SW_A);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("async_leds", {16'h0, leds}, 32'h0);
        check_eq("async_rdata", io_rdata, 32'h0);
        cycle();
        cycle();
        reset = 1'b1;
        drive_read(EVT_A);
        #1;
        check_eq("post_rst_evt", io_rdata, 32'h0);
        expect_accept("rst_accept", {16'h0, sw_raw});

        // 6. simultaneous read and write
        drive_write(LED_A, 32'h0000_1234);
        cycle();
        io_read = 1'b1; io_write = 1'b1; io_addr = LED_A; io_wdata = 32'hBEEF_5678;
        #1;
        check_eq("rw_rdata", io_rdata, 32'h0000_1234);
        cycle();
        check_eq("rw_leds", {16'h0, leds}, 32'h0000_5678);
        drive_idle();
        cycle();

        // randomized traffic against the model
        addr_tbl[0] = LED_A; addr_tbl[1] = SW_A; addr_tbl[2] = EVT_A;
        addr_tbl[3] = LED_A + 32'd4;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) sw_raw = sw_raw ^ (16'h1 << $urandom_range(0, 15));
            addr_tbl[4] = $urandom;
            io_read  = 1'($urandom_range(0, 1));
            io_write = ($urandom_range(0, 3) == 0);
            io_addr  = addr_tbl[$urandom_range(0, 4)];
            io_wdata = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
